// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_sync_param FIFO family.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 8;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    // Address width for a memory of 'depth' entries; never below 1 bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, combinational read.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, threshold flags and selectable FWFT read.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] AF_LVL = (PTR_W + 1)'(AF_THRESH);
    localparam logic [PTR_W:0] AE_LVL = (PTR_W + 1)'(AE_THRESH);
    localparam read_mode_e MODE = (FWFT != 0) ? READ_FWFT : READ_STD;

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Extra MSB distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[PTR_W-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[PTR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    if (MODE == READ_STD) begin : g_std
        logic [WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = ram_rdata;
        end

        always_ff @(posedge clk) begin
            if (rst) dout_q <= '0;
            else     dout_q <= dout_d;
        end

        assign data_out = dout_q;
    end else begin : g_fwft
        // Head is presented directly; forced to zero while empty so reset reads as 0.
        assign data_out = empty ? '0 : ram_rdata;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (wr_en && full)  ovf_d = 1'b1;
            if (rd_en && empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: one standard-read and one FWFT instance, DEPTH=4.
module tb_fifo_sync_param;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-read instance
    logic       s_rst, s_wr, s_rd, s_clr;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [2:0] s_cnt;

    // FWFT instance
    logic       f_rst, f_wr, f_rd, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] f_cnt;

    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_std (
        .clk(clk), .rst(s_rst), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_cnt), .err_clr(s_clr), .overflow(s_ovf),
        .underflow(s_unf)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_fw (
        .clk(clk), .rst(f_rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt), .err_clr(f_clr), .overflow(f_ovf),
        .underflow(f_unf)
    );

    // Reference state
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf, exp_unf;
    logic [7:0] fexp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s_step(input string tag, input logic r, input logic w, input logic [7:0] d,
                          input logic rd, input logic clr);
        bit full_m, empty_m;
        s_rst = r; s_wr = w; s_din = d; s_rd = rd; s_clr = clr;
        full_m  = (exp_q.size() == 4);
        empty_m = (exp_q.size() == 0);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            exp_dout = 8'h00;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
        end else begin
            if (rd && !empty_m) exp_dout = exp_q.pop_front();
            if (w && !full_m) exp_q.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
            if (clr) begin
                exp_ovf = 1'b0;
                exp_unf = 1'b0;
            end else begin
                if (w && full_m)   exp_ovf = 1'b1;
                if (rd && empty_m) exp_unf = 1'b1;
            end
`endif
        end
        #1;
        chk({tag, ".count"}, 32'(s_cnt), 32'(exp_q.size()));
        chk({tag, ".empty"}, 32'(s_empty), 32'(exp_q.size() == 0));
        chk({tag, ".full"},  32'(s_full),  32'(exp_q.size() == 4));
        chk({tag, ".afull"}, 32'(s_af),    32'(exp_q.size() >= 3));
        chk({tag, ".aempty"}, 32'(s_ae),   32'(exp_q.size() <= 1));
        chk({tag, ".dout"},  32'(s_dout),  32'(exp_dout));
        chk({tag, ".ovf"},   32'(s_ovf),   32'(exp_ovf));
        chk({tag, ".unf"},   32'(s_unf),   32'(exp_unf));
    endtask

    task automatic f_step(input string tag, input logic r, input logic w, input logic [7:0] d,
                          input logic rd);
        bit full_m, empty_m;
        f_rst = r; f_wr = w; f_din = d; f_rd = rd; f_clr = 1'b0;
        full_m  = (fexp_q.size() == 4);
        empty_m = (fexp_q.size() == 0);
        @(posedge clk);
        if (r) begin
            fexp_q.delete();
        end else begin
            if (rd && !empty_m) void'(fexp_q.pop_front());
            if (w && !full_m) fexp_q.push_back(d);
        end
        #1;
        chk({tag, ".count"}, 32'(f_cnt),   32'(fexp_q.size()));
        chk({tag, ".empty"}, 32'(f_empty), 32'(fexp_q.size() == 0));
        chk({tag, ".full"},  32'(f_full),  32'(fexp_q.size() == 4));
        if (fexp_q.size() != 0) chk({tag, ".head"}, 32'(f_dout), 32'(fexp_q[0]));
    endtask

    initial begin
        int wr_idx;
        int cyc;
        logic w, rd;

        s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_din = 8'h00;
        f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = 8'h00;
        exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;

        // Reset for two cycles
        s_step("rst0", 1, 0, 8'h00, 0, 0);
        s_step("rst1", 1, 0, 8'h00, 0, 0);
        chk("rst.dout_zero", 32'(s_dout), 32'h00);
        chk("rst.af_low", 32'(s_af), 32'h0);

        // Fill to full, then overflow attempt
        s_step("wrA1", 0, 1, 8'hA1, 0, 0);
        s_step("wrA2", 0, 1, 8'hA2, 0, 0);
        s_step("wrA3", 0, 1, 8'hA3, 0, 0);
        chk("fill.af_at3", 32'(s_af), 32'h1);
        s_step("wrA4", 0, 1, 8'hA4, 0, 0);
        chk("fill.full_at4", 32'(s_full), 32'h1);
        s_step("wrA5", 0, 1, 8'hA5, 0, 0);
        chk("fill.cnt_stays4", 32'(s_cnt), 32'd4);

        // Drain and underflow, then clear
        s_step("rd1", 0, 0, 8'h00, 1, 0);
        chk("drain.A1", 32'(s_dout), 32'hA1);
        s_step("rd2", 0, 0, 8'h00, 1, 0);
        chk("drain.A2", 32'(s_dout), 32'hA2);
        s_step("rd3", 0, 0, 8'h00, 1, 0);
        chk("drain.A3", 32'(s_dout), 32'hA3);
        s_step("rd4", 0, 0, 8'h00, 1, 0);
        chk("drain.A4", 32'(s_dout), 32'hA4);
        s_step("rd5", 0, 0, 8'h00, 1, 0);
        chk("drain.hold_A4", 32'(s_dout), 32'hA4);
        s_step("clr", 0, 0, 8'h00, 0, 1);
        chk("clr.unf_low", 32'(s_unf), 32'h0);

        // Simultaneous traffic at count=2
        s_step("pre20", 0, 1, 8'h20, 0, 0);
        s_step("pre21", 0, 1, 8'h21, 0, 0);
        for (int i = 0; i < 6; i++) begin
            s_step($sformatf("wr_rd%0d", i), 0, 1, 8'(8'h10 + i), 1, 0);
        end
        chk("sim.last_out", 32'(s_dout), 32'h13);

        // Simultaneous at full: write dropped
        s_step("pre30", 0, 1, 8'h30, 0, 0);
        s_step("pre31", 0, 1, 8'h31, 0, 0);
        s_step("full_wr_rd", 0, 1, 8'h99, 1, 0);
        chk("fullwr.cnt3", 32'(s_cnt), 32'd3);
        s_step("dr15", 0, 0, 8'h00, 1, 0);
        s_step("dr30", 0, 0, 8'h00, 1, 0);
        s_step("dr31", 0, 0, 8'h00, 1, 0);
        chk("fullwr.last31", 32'(s_dout), 32'h31);

        // Simultaneous at empty: read rejected
        s_step("empty_wr_rd", 0, 1, 8'h77, 1, 0);
        chk("emptywr.cnt1", 32'(s_cnt), 32'd1);
        chk("emptywr.dout_hold", 32'(s_dout), 32'h31);

        // Reset mid-operation with a write pending
        s_step("pre78", 0, 1, 8'h78, 0, 0);
        s_step("pre79", 0, 1, 8'h79, 0, 0);
        s_step("rst_mid", 1, 1, 8'hEE, 0, 0);
        chk("rstmid.cnt0", 32'(s_cnt), 32'd0);
        s_step("post_rd", 0, 0, 8'h00, 1, 0);
        s_step("post42w", 0, 1, 8'h42, 0, 0);
        s_step("post42r", 0, 0, 8'h00, 1, 0);
        chk("rstmid.42", 32'(s_dout), 32'h42);

        // FWFT: reset, random stream across pointer wraps
        f_step("frst0", 1, 0, 8'h00, 0);
        f_step("frst1", 1, 0, 8'h00, 0);
        wr_idx = 0;
        cyc = 0;
        while ((wr_idx < 20 || fexp_q.size() != 0) && cyc < 400) begin
            w  = (wr_idx < 20) && ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 1) == 1);
            f_step("stream", 0, w, 8'(wr_idx), rd);
            if (w && fexp_q.size() != 0 && fexp_q[fexp_q.size()-1] == 8'(wr_idx)) wr_idx++;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 400) begin
            n_err++;
            $error("FAIL stream_timeout: observed %0d cycles expected under 400", cyc);
        end

        // FWFT fall-through latency into an empty FIFO
        f_step("f5c", 0, 1, 8'h5C, 0);
        chk("fwft.5c_visible", 32'(f_dout), 32'h5C);
        f_step("f5c_hold", 0, 0, 8'h00, 0);
        f_step("f5c_pop", 0, 0, 8'h00, 1);

        s_wr = 1'b0; s_rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO and successor to the basic fifo block. It uses extra-bit pointers, so all DEPTH entries are usable. It adds an occupancy count, programmable almost-full/almost-empty flags, and a selectable first-word-fall-through (FWFT) read mode. It is the general-purpose buffer for storage/ and for stream blocks that need back-pressure thresholds.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
data_in  input  WIDTH  write data
rd_en  input  1  read request (pop in FWFT mode)
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
err_clr  input  1  clears sticky error flags (optional feature)
overflow  output  1  sticky: write attempted while full (optional feature)
underflow  output  1  sticky: read attempted while empty (optional feature)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), data_out=0, overflow=0, underflow=0.
- Reset does not clear memory. Contents are unobservable until written.
- Reset mid-operation discards all entries. The state one cycle after rst is identical to the post-reset state.
- Pointers are PTR_W+1 bits, with PTR_W=$clog2(DEPTH). The low PTR_W bits address memory, and the MSB toggles on wrap.
- full: MSBs differ and low bits are equal. empty: pointers are equal.
- count = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- Write accept: wr_acc = wr_en && !full. On accept, mem[wr_ptr[PTR_W-1:0]] <= data_in and wr_ptr increments.
- Read accept: rd_acc = rd_en && !empty. On accept, rd_ptr increments.
- Flags and count are combinational from registered pointers, so they update the cycle after an accepted operation.
- Simultaneous wr_en and rd_en:
  - Normal: both are accepted and count is unchanged.
  - When full: the read is accepted and the write is rejected; count becomes DEPTH-1.
  - When empty: the write is accepted and the read is rejected; count becomes 1.
  - No bypass of the new word to the read side in the same cycle.
- FWFT=0 (standard read):
  - On rd_acc, data_out <= mem[rd_ptr], valid on the cycle after rd_en (1-cycle latency).
  - Otherwise data_out holds its last value.
- FWFT=1 (fall-through read):
  - data_out = mem[rd_ptr] combinationally; it is valid whenever !empty.
  - rd_en pops the head, and the next head appears in the following cycle.
  - A word written into an empty FIFO appears on data_out the cycle after the write.
  - data_out is don't-care while empty; the bench checks it only when !empty.
- Wrap-around: pointers wrap naturally. No special case is needed at index DEPTH-1 to 0.
- Rejected operations leave all pointers, memory and count unchanged.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle with wr_en && full.
  - underflow sets on any cycle with rd_en && empty.
  - Both are sticky until rst or err_clr.
  - err_clr has priority over a same-cycle set, so that cycle clears the flag.
- Undefined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
- Ports exist in both builds.

Decomposition:
- Package fifo_pkg holds:
  - the ptr_width function (clog2 helper);
  - localparam defaults FIFO_DEF_WIDTH=8 and FIFO_DEF_DEPTH=8;
  - a READ_MODE encoding constant (STD=0, FWFT=1).
- One sub-module, fifo_ram: simple dual-port RAM.
  - Inputs: synchronous write port, plus a read address.
  - Outputs: combinational read data.
  - It is shared by both read modes. The FWFT=0 output register lives in fifo_sync_param.

Test Plan:
- Reset (WIDTH=8, DEPTH=4): assert rst for 2 cycles -> empty=1, full=0, count=0, data_out=0x00, almost_empty=1.
- Fill/overflow (FWFT=0, AF_THRESH=3): write 0xA1..0xA4 -> almost_full=1 at count=3, full=1 at count=4. A 5th write of 0xA5 is rejected, count stays 4, and overflow=1 with the macro (0 without).
- Drain/underflow: rd_en four times -> data_out = 0xA1, 0xA2, 0xA3, 0xA4, each one cycle after its rd_en. empty=1 after the last read. An extra read leaves data_out at 0xA4 and sets underflow=1; err_clr then drops it to 0.
- Simultaneous operations:
  - At count=2, wr+rd for 6 cycles (data 0x10..0x15) -> count stays 2 and output order is preserved.
  - At full, wr+rd -> count=3 and the written word is dropped.
  - At empty, wr+rd -> count=1 and data_out is unchanged.
- Wrap and FWFT (FWFT=1):
  - Stream 20 words 0x00..0x13 with random wr_en/rd_en -> output exactly matches the input order across multiple pointer wraps.
  - Write 0x5C into an empty FIFO -> data_out=0x5C the next cycle with no rd_en.
- Reset mid-operation: at count=3 with wr_en=1, pulse rst for 1 cycle -> next cycle count=0, empty=1, data_out=0, and the write in the reset cycle is not stored.
